// File: rtl/conv_window_fetch_if.sv
// Bundle between the window fetcher, its image buffer and the convolution engine.
// The fetcher sits on the master side. The loader, buffer and engine sit on the slave side.
interface conv_window_fetch_if #(
  parameter int unsigned DATA_SIZE      = 16,
  parameter int unsigned IMG_SIZE_WIDTH = 6,
  parameter int unsigned BUF_ADDR_W     = 10,
  parameter int unsigned KERNEL_SIZE    = 5
) ();
  logic                                            start;
  logic [IMG_SIZE_WIDTH-1:0]                       imgSize;
  logic                                            rd_en;
  logic [BUF_ADDR_W-1:0]                           rd_addr;
  logic [DATA_SIZE-1:0]                            rd_data;
  logic                                            win_valid;
  logic                                            win_ready;
  logic [KERNEL_SIZE*KERNEL_SIZE*DATA_SIZE-1:0]    window;
  logic [IMG_SIZE_WIDTH-1:0]                       win_row;
  logic [IMG_SIZE_WIDTH-1:0]                       win_col;
  logic                                            busy;
  logic                                            done;
  logic                                            err;

  modport master (
    input  start, imgSize, rd_data, win_ready,
    output rd_en, rd_addr, win_valid, window, win_row, win_col, busy, done, err
  );

  modport slave (
    output start, imgSize, rd_data, win_ready,
    input  rd_en, rd_addr, win_valid, window, win_row, win_col, busy, done, err
  );
endinterface

// File: rtl/conv_window_fetch.sv
// Walks a row-major NxN image buffer and emits one KxK window per output position.
// Windows use stride 1 and valid padding, and each one is presented over valid/ready.
module conv_window_fetch #(
  parameter int unsigned DATA_SIZE      = 16,
  parameter int unsigned IMG_SIZE_WIDTH = 6,
  parameter int unsigned BUF_ADDR_W     = 10,
  parameter int unsigned KERNEL_SIZE    = 5
) (
  input logic                 clk,
  input logic                 rst_n,
  conv_window_fetch_if.master bus
);
  localparam int unsigned KK    = KERNEL_SIZE * KERNEL_SIZE;
  localparam int unsigned KW    = $clog2(KK);
  localparam int unsigned KCW   = $clog2(KERNEL_SIZE);
  localparam int unsigned SumW  = IMG_SIZE_WIDTH + 1;
  localparam int unsigned FullW = 2 * SumW;

  localparam logic [KW-1:0]             KLast  = KW'(KK - 1);
  localparam logic [KCW-1:0]            KcLast = KCW'(KERNEL_SIZE - 1);
  localparam logic [IMG_SIZE_WIDTH-1:0] KSize  = IMG_SIZE_WIDTH'(KERNEL_SIZE);

  typedef enum logic [2:0] {StIdle, StFetch, StDrain, StPresent, StFinish} state_e;

  state_e                    state_q, state_d;
  logic [IMG_SIZE_WIDTH-1:0] n_q, n_d, r_q, r_d, c_q, c_d;
  logic [KW-1:0]             k_q, k_d;
  logic [KCW-1:0]            kr_q, kr_d, kc_q, kc_d;
  logic                      err_q, err_d;
  logic                      cap_q;
  logic [KW-1:0]             cap_idx_q;
  logic [DATA_SIZE-1:0]      win_mem [KK];
  logic [KK*DATA_SIZE-1:0]   window_flat;

  logic                      rd_en;
  logic [31:0]               size_sq;
  logic                      size_ok;
  logic [SumW-1:0]           row_sum, col_sum;
  logic [FullW-1:0]          full_addr;
  logic                      unused_addr_hi;

  // Window side N must fit a KxK kernel, and the NxN image must fit in the buffer.
  assign size_sq = 32'(bus.imgSize) * 32'(bus.imgSize);
  assign size_ok = (bus.imgSize >= KSize) && (size_sq <= (32'd1 << BUF_ADDR_W));

  // kr/kc run alongside k, so the address needs no divider.
  assign row_sum   = SumW'(r_q) + SumW'(kr_q);
  assign col_sum   = SumW'(c_q) + SumW'(kc_q);
  assign full_addr = FullW'(row_sum) * FullW'(n_q) + FullW'(col_sum);
  // The upper bits are zero for every legal N.
  assign unused_addr_hi = ^full_addr[FullW-1:BUF_ADDR_W];

  // State and counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      n_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      k_q     <= '0;
      kr_q    <= '0;
      kc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      r_q     <= r_d;
      c_q     <= c_d;
      k_q     <= k_d;
      kr_q    <= kr_d;
      kc_q    <= kc_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: fetch K*K elements, drain one cycle, present, then advance (r,c)
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    r_d     = r_q;
    c_d     = c_q;
    k_d     = k_q;
    kr_d    = kr_q;
    kc_d    = kc_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          n_d     = bus.imgSize;
          err_d   = ~size_ok;
          r_d     = '0;
          c_d     = '0;
          k_d     = '0;
          kr_d    = '0;
          kc_d    = '0;
          state_d = size_ok ? StFetch : StFinish;
        end
      end
      StFetch: begin
        k_d = k_q + 1'b1;
        if (kc_q == KcLast) begin
          kc_d = '0;
          kr_d = kr_q + 1'b1;
        end else begin
          kc_d = kc_q + 1'b1;
        end
        if (k_q == KLast) state_d = StDrain;
      end
      StDrain: state_d = StPresent;
      StPresent: begin
        if (bus.win_ready) begin
          k_d  = '0;
          kr_d = '0;
          kc_d = '0;
          if (c_q < n_q - KSize) begin
            c_d     = c_q + 1'b1;
            state_d = StFetch;
          end else if (r_q < n_q - KSize) begin
            r_d     = r_q + 1'b1;
            c_d     = '0;
            state_d = StFetch;
          end else begin
            state_d = StFinish;
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Buffer data arrives one cycle after issue, so capture into the element issued last cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q     <= 1'b0;
      cap_idx_q <= '0;
      for (int i = 0; i < KK; i++) win_mem[i] <= '0;
    end else begin
      cap_q     <= rd_en;
      cap_idx_q <= k_q;
      if (cap_q) win_mem[cap_idx_q] <= bus.rd_data;
    end
  end

  for (genvar g = 0; g < KK; g++) begin : g_pack
    assign window_flat[g*DATA_SIZE +: DATA_SIZE] = win_mem[g];
  end

  assign rd_en         = (state_q == StFetch);
  assign bus.rd_en     = rd_en;
  assign bus.rd_addr   = rd_en ? full_addr[BUF_ADDR_W-1:0] : '0;
  assign bus.win_valid = (state_q == StPresent);
  assign bus.window    = window_flat;
  assign bus.win_row   = r_q;
  assign bus.win_col   = c_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = (state_q == StFinish);
  assign bus.err       = err_q;
endmodule

// File: tb/tb_conv_window_fetch.sv
// Scoreboard bench for conv_window_fetch.
// Stimulus pushes the expected read addresses and windows into queues.
// A negedge monitor pops them and compares them against the DUT.
module tb_conv_window_fetch;
  localparam int DW = 16;
  localparam int IW = 6;
  localparam int AW = 10;
  localparam int K  = 5;

  typedef struct packed {
    logic [IW-1:0]       row;
    logic [IW-1:0]       col;
    logic [K*K*DW-1:0]   win;
  } win_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_window_fetch_if #(
    .DATA_SIZE(DW), .IMG_SIZE_WIDTH(IW), .BUF_ADDR_W(AW), .KERNEL_SIZE(K)
  ) bus ();

  conv_window_fetch #(
    .DATA_SIZE(DW), .IMG_SIZE_WIDTH(IW), .BUF_ADDR_W(AW), .KERNEL_SIZE(K)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] mem [1 << AW];
  win_t          exp_q[$];
  logic [AW-1:0] addr_q[$];
  int tests = 0;
  int fails = 0;
  int win_cnt = 0;
  int done_cnt = 0;
  int max_addr = 0;
  logic [IW-1:0]     last_row;
  logic [IW-1:0]     last_col;
  logic [K*K*DW-1:0] last_win;

  task automatic chk(input string name, input logic [K*K*DW-1:0] act,
                     input logic [K*K*DW-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Buffer model: one-cycle read latency
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.rd_data <= '0;
    else if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
  end

  // Monitor: check reads and accepted windows against the scoreboard
  always @(negedge clk) begin
    win_t e;
    if (rst_n) begin
      if (bus.rd_en) begin
        if (addr_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rd_addr: got read at %0d required no read", bus.rd_addr);
        end else begin
          chk("rd_addr", bus.rd_addr, addr_q.pop_front());
        end
        if (int'(bus.rd_addr) > max_addr) max_addr = int'(bus.rd_addr);
      end
      if (bus.win_valid && bus.win_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL window: got window (%0d,%0d) required none", bus.win_row, bus.win_col);
        end else begin
          e = exp_q.pop_front();
          chk("win_row", bus.win_row, e.row);
          chk("win_col", bus.win_col, e.col);
          chk("window", bus.window, e.win);
        end
        win_cnt++;
        last_row = bus.win_row;
        last_col = bus.win_col;
        last_win = bus.window;
      end
      if (bus.done) done_cnt++;
    end
  end

  task automatic push_pass(input int n);
    win_t e;
    for (int r = 0; r <= n - K; r++) begin
      for (int c = 0; c <= n - K; c++) begin
        e.row = IW'(r);
        e.col = IW'(c);
        e.win = '0;
        for (int k = 0; k < K * K; k++) begin
          int a;
          a = (r + k / K) * n + c + k % K;
          addr_q.push_back(AW'(a));
          e.win[k*DW +: DW] = mem[a];
        end
        exp_q.push_back(e);
      end
    end
  endtask

  // Pulse start for one edge; returns #1 after the edge that samples it
  task automatic kick(input int n);
    bus.imgSize = IW'(n);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (bus.done !== 1'b1 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("done within budget", bus.done, 1'b1);
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (bus.win_valid !== 1'b1 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("win_valid within budget", bus.win_valid, 1'b1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " rd_en"}, bus.rd_en, 0);
    chk({tag, " rd_addr"}, bus.rd_addr, 0);
    chk({tag, " win_valid"}, bus.win_valid, 0);
    chk({tag, " window"}, bus.window, 0);
    chk({tag, " win_row"}, bus.win_row, 0);
    chk({tag, " win_col"}, bus.win_col, 0);
    chk({tag, " busy"}, bus.busy, 0);
    chk({tag, " done"}, bus.done, 0);
    chk({tag, " err"}, bus.err, 0);
  endtask

  task automatic end_pass(input string tag, input int wc0, input int dc0, input int nwin);
    repeat (2) @(posedge clk);
    #1;
    chk({tag, " window count"}, win_cnt - wc0, nwin);
    chk({tag, " done count"}, done_cnt - dc0, 1);
    chk({tag, " reads left"}, addr_q.size(), 0);
    chk({tag, " windows left"}, exp_q.size(), 0);
  endtask

  initial begin
    int lat;
    int wc0;
    int dc0;
    logic [K*K*DW-1:0] w;
    logic [IW-1:0] sr, sc;

    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i);
    bus.start = 1'b0;
    bus.imgSize = '0;
    bus.win_ready = 1'b0;

    // Reset state
    #1;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single window, N=5: latency 26 edges, element k holds k
    wc0 = win_cnt;
    dc0 = done_cnt;
    push_pass(5);
    kick(5);
    lat = 0;
    while (bus.win_valid !== 1'b1 && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("single latency", lat, 26);
    w = bus.window;
    for (int k = 0; k < K * K; k++) chk("single element", w[k*DW +: DW], k);
    bus.win_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("single done", bus.done, 1);
    chk("single busy in finish", bus.busy, 1);
    chk("single valid dropped", bus.win_valid, 0);
    bus.win_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("single done cleared", bus.done, 0);
    chk("single busy cleared", bus.busy, 0);
    end_pass("single", wc0, dc0, 1);

    // Multi-window, N=7 with win_ready held high
    wc0 = win_cnt;
    dc0 = done_cnt;
    bus.win_ready = 1'b1;
    push_pass(7);
    kick(7);
    wait_done(1000);
    end_pass("multi", wc0, dc0, 9);

    // Backpressure, N=6, plus a start pulse during PRESENT that must be ignored
    wc0 = win_cnt;
    dc0 = done_cnt;
    bus.win_ready = 1'b0;
    push_pass(6);
    kick(6);
    wait_valid(60);
    w = bus.window;
    sr = bus.win_row;
    sc = bus.win_col;
    for (int i = 0; i < 10; i++) begin
      bus.start = (i == 4);
      bus.imgSize = IW'(5);
      @(posedge clk);
      #1;
      chk("hold window", bus.window, w);
      chk("hold row", bus.win_row, sr);
      chk("hold col", bus.win_col, sc);
      chk("hold no read", bus.rd_en, 0);
      chk("hold valid", bus.win_valid, 1);
    end
    bus.start = 1'b0;
    bus.win_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release fetch", bus.rd_en, 1);
    wait_done(1000);
    end_pass("backpressure", wc0, dc0, 4);

    // Illegal sizes N=4 and N=33, then a legal start clears err
    dc0 = done_cnt;
    kick(4);
    chk("n4 err", bus.err, 1);
    chk("n4 done", bus.done, 1);
    @(posedge clk);
    #1;
    chk("n4 done cleared", bus.done, 0);
    chk("n4 busy cleared", bus.busy, 0);
    chk("n4 err sticky", bus.err, 1);
    kick(33);
    chk("n33 err", bus.err, 1);
    chk("n33 done", bus.done, 1);
    @(posedge clk);
    #1;
    chk("n33 err sticky", bus.err, 1);
    chk("illegal done count", done_cnt - dc0, 2);
    wc0 = win_cnt;
    dc0 = done_cnt;
    push_pass(5);
    kick(5);
    chk("legal clears err", bus.err, 0);
    wait_done(1000);
    end_pass("after illegal", wc0, dc0, 1);

    // Max size N=32: 784 windows, last read from address 1023
    wc0 = win_cnt;
    dc0 = done_cnt;
    max_addr = 0;
    push_pass(32);
    kick(32);
    wait_done(30000);
    end_pass("max", wc0, dc0, 784);
    chk("max last row", last_row, 27);
    chk("max last col", last_col, 27);
    chk("max last element", last_win[24*DW +: DW], 1023);
    chk("max address", max_addr, 1023);

    // Asynchronous reset mid-FETCH
    bus.win_ready = 1'b0;
    push_pass(6);
    kick(6);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async reset");
    addr_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle after reset", bus.busy, 0);
    wc0 = win_cnt;
    dc0 = done_cnt;
    bus.win_ready = 1'b1;
    push_pass(5);
    kick(5);
    wait_done(1000);
    end_pass("after reset", wc0, dc0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
